// File: rtl/sigmoid_backprop_delta_pkg.sv
// Shared constants, FSM state encoding and small fp32 sign helpers for the sigmoid backprop block.
package sigmoid_backprop_delta_pkg;

  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          SIGN_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SUB1 = 3'd1,
    ST_SUB2 = 3'd2,
    ST_MUL1 = 3'd3,
    ST_MUL2 = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // Negation is just a sign flip, so the shared adder doubles as the subtractor.
  function automatic logic [31:0] fp_neg(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    r[SIGN_BIT] = ~v[SIGN_BIT];
    return r;
  endfunction

  function automatic logic [31:0] fp_canon(input logic [31:0] v, input logic en);
    if (en && (v[30:0] == 31'd0)) return FP_ZERO;
    return v;
  endfunction

endpackage

// File: rtl/Floating_Point_Adder.sv
// Combinational IEEE-754 binary32 adder, round-to-nearest-even, gradual underflow.
module Floating_Point_Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [31:0] x, y;
  logic [7:0]  ex, ey, dexp;
  logic [26:0] mx, my, my_sh, m;
  logic [27:0] sum;
  logic [9:0]  e;
  logic [24:0] r;
  logic        sub, x_nan, y_nan, x_inf, y_inf;

  always_comb begin
    x = a;
    y = b;
    if (a[30:0] < b[30:0]) begin
      x = b;
      y = a;
    end
    x_nan = (&x[30:23]) && (|x[22:0]);
    y_nan = (&y[30:23]) && (|y[22:0]);
    x_inf = (&x[30:23]) && !(|x[22:0]);
    y_inf = (&y[30:23]) && !(|y[22:0]);
    ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    mx    = {|x[30:23], x[22:0], 3'b000};
    my    = {|y[30:23], y[22:0], 3'b000};
    dexp  = ex - ey;
    sub   = x[31] ^ y[31];

    // Align the smaller operand; everything shifted out collapses into the sticky bit.
    if (dexp > 8'd26) begin
      my_sh = {26'd0, |my};
    end else begin
      my_sh = my >> dexp;
      if ((my_sh << dexp) != my) my_sh[0] = 1'b1;
    end

    sum = sub ? ({1'b0, mx} - {1'b0, my_sh}) : ({1'b0, mx} + {1'b0, my_sh});
    e   = {2'b00, ex};

    if (sum[27]) begin
      m = {sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end else begin
      m = sum[26:0];
      for (int i = 0; i < 26; i++) begin
        if (!m[26] && (e > 10'd1)) begin
          m = m << 1;
          e = e - 10'd1;
        end
      end
    end

    r = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'd1;
    end

    if (x_nan || y_nan || (x_inf && y_inf && sub)) begin
      result = 32'h7FC0_0000;
    end else if (x_inf) begin
      result = {x[31], 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      result = {x[31] & y[31], 31'd0};
    end else if (e >= 10'd255) begin
      result = {x[31], 8'hFF, 23'd0};
    end else begin
      result = {x[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
    end
  end

endmodule

// File: rtl/Floating_Point_Multiplier.sv
// Combinational IEEE-754 binary32 multiplier, round-to-nearest-even, gradual underflow.
module Floating_Point_Multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic               sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0]         ea, eb;
  logic [23:0]        ma, mb;
  logic [47:0]        p, m, tmp;
  logic signed [11:0] e, sh;
  logic [24:0]        r;

  always_comb begin
    sgn    = a[31] ^ b[31];
    a_nan  = (&a[30:23]) && (|a[22:0]);
    b_nan  = (&b[30:23]) && (|b[22:0]);
    a_inf  = (&a[30:23]) && !(|a[22:0]);
    b_inf  = (&b[30:23]) && !(|b[22:0]);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    ea     = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb     = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma     = {|a[30:23], a[22:0]};
    mb     = {|b[30:23], b[22:0]};
    p      = 48'(ma) * 48'(mb);
    e      = 12'(ea) + 12'(eb) - 12'sd126;
    m      = p;
    tmp    = '0;
    sh     = '0;

    for (int i = 0; i < 47; i++) begin
      if (!m[47] && (m != 48'd0)) begin
        m = m << 1;
        e = e - 12'sd1;
      end
    end

    // Below the normal range: denormalise with sticky so rounding still sees the lost bits.
    if (e < 12'sd1) begin
      sh = 12'sd1 - e;
      if (sh > 12'sd47) begin
        m = {47'd0, |m};
      end else begin
        tmp = m >> sh;
        if ((tmp << sh) != m) tmp[0] = 1'b1;
        m = tmp;
      end
      e = 12'sd1;
    end

    r = {1'b0, m[47:24]} + {24'd0, m[23] & (m[24] | (|m[22:0]))};
    if (r[24]) begin
      r = r >> 1;
      e = e + 12'sd1;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      result = {sgn, 8'hFF, 23'd0};
    end else if (p == 48'd0) begin
      result = {sgn, 31'd0};
    end else if (e >= 12'sd255) begin
      result = {sgn, 8'hFF, 23'd0};
    end else begin
      result = {sgn, r[23] ? e[7:0] : 8'd0, r[22:0]};
    end
  end

endmodule

// File: rtl/fp_op_timer.sv
// Counts OP_WAIT cycles while run is high; done marks the last cycle of the slot.
// Clears itself whenever run drops or done fires, so every FSM state entry starts a fresh slot.
module fp_op_timer #(
  parameter int OP_WAIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic done
);

  localparam int W = $clog2(OP_WAIT + 1);
  localparam logic [W-1:0] LAST = W'(OP_WAIT - 1);

  logic [W-1:0] cnt;

  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sigmoid_backprop_delta.sv
// Sigmoid backprop: deriv = y*(1-y), delta = (t-y)*deriv, on one shared fp32 adder and multiplier.
// out_valid 4*OP_WAIT cycles after accept; results held while out_ready is low, in_ready only in IDLE.
module sigmoid_backprop_delta
  import sigmoid_backprop_delta_pkg::*;
#(
  parameter int OP_WAIT    = 1,
  parameter bit ZERO_CANON = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] y_in,
  input  logic [31:0] t_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] deriv_out,
  output logic [31:0] delta_out
);

  state_t      state_q, state_d;
  logic [31:0] y_q, t_q, om1_q, tmy_q, d_q;
  logic [31:0] add_a, add_b, add_res, mul_a, mul_b, mul_res;
  logic        op_run, op_done;

  fp_op_timer #(.OP_WAIT(OP_WAIT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .run  (op_run),
    .done (op_done)
  );

  Floating_Point_Adder u_add (
    .a      (add_a),
    .b      (add_b),
    .result (add_res)
  );

  Floating_Point_Multiplier u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .result (mul_res)
  );

  // Operand muxes select only among registers, so the shared units see stable inputs per slot.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    op_run    = 1'b0;
    add_a     = FP_ZERO;
    add_b     = FP_ZERO;
    mul_a     = FP_ZERO;
    mul_b     = FP_ZERO;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_SUB1;
      end
      ST_SUB1: begin
        op_run = 1'b1;
        add_a  = FP_ONE;
        add_b  = fp_neg(y_q);
        if (op_done) state_d = ST_SUB2;
      end
      ST_SUB2: begin
        op_run = 1'b1;
        add_a  = t_q;
        add_b  = fp_neg(y_q);
        if (op_done) state_d = ST_MUL1;
      end
      ST_MUL1: begin
        op_run = 1'b1;
        mul_a  = y_q;
        mul_b  = om1_q;
        if (op_done) state_d = ST_MUL2;
      end
      ST_MUL2: begin
        op_run = 1'b1;
        mul_a  = d_q;
        mul_b  = tmy_q;
        if (op_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= FP_ZERO;
      t_q       <= FP_ZERO;
      om1_q     <= FP_ZERO;
      tmy_q     <= FP_ZERO;
      d_q       <= FP_ZERO;
      deriv_out <= FP_ZERO;
      delta_out <= FP_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          y_q <= y_in;
          t_q <= t_in;
        end
        ST_SUB1: if (op_done) om1_q <= add_res;
        ST_SUB2: if (op_done) tmy_q <= add_res;
        ST_MUL1: if (op_done) d_q <= mul_res;
        ST_MUL2: if (op_done) begin
          deriv_out <= fp_canon(d_q, ZERO_CANON);
          delta_out <= fp_canon(mul_res, ZERO_CANON);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_backprop_delta.sv
// Bench for sigmoid_backprop_delta: directed cases plus random pairs against a real-arithmetic reference.
module tb_sigmoid_backprop_delta;

  localparam int OW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] y_in = '0;
  logic [31:0] t_in = '0;
  logic        in_ready, out_valid;
  logic [31:0] deriv_out, delta_out;

  int tests = 0;
  int fails = 0;

  sigmoid_backprop_delta #(.OP_WAIT(OW), .ZERO_CANON(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .t_in      (t_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .deriv_out (deriv_out),
    .delta_out (delta_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fp32 (normal or zero) to real, exactly
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    if (f[30:0] == 31'd0) return 0.0;
    b = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  // real to fp32 with round-to-nearest-even; exact zero maps to 0x00000000
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [7:0]  e;
    logic [23:0] k;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = 8'(b[62:52] - 11'd896);
    k = {1'b0, b[51:29]} + {23'd0, b[28] & ((|b[27:0]) | b[29])};
    if (k[23]) e = e + 8'd1;
    return {b[63], e, k[22:0]};
  endfunction

  task automatic model(input logic [31:0] y, input logic [31:0] t,
                       output logic [31:0] ed, output logic [31:0] edl);
    logic [31:0] om1, tmy;
    om1 = r2f(1.0 - f2r(y));
    tmy = r2f(f2r(t) - f2r(y));
    ed  = r2f(f2r(y) * f2r(om1));
    edl = r2f(f2r(ed) * f2r(tmy));
  endtask

  task automatic start_pair(input logic [31:0] y, input logic [31:0] t);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    y_in = y;
    t_in = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_pair(input string tag, input logic [31:0] ed, input logic [31:0] edl,
                             input int hold);
    int lat;
    wait_done(lat);
    check({tag, "_latency"}, lat, 4 * OW);
    check({tag, "_deriv"}, deriv_out, ed);
    check({tag, "_delta"}, delta_out, edl);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ry, rt, ed, edl;
    int lat;

    // Reset state while rst is held
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_deriv", deriv_out, 32'h0);
    check("rst_delta", delta_out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed vectors
    start_pair(32'h3F00_0000, 32'h3F80_0000);
    finish_pair("t1", 32'h3E80_0000, 32'h3E00_0000, 0);
    start_pair(32'h3F40_0000, 32'h3F80_0000);
    finish_pair("t2", 32'h3E40_0000, 32'h3D40_0000, 1);
    start_pair(32'h3F00_0000, 32'h0000_0000);
    finish_pair("t3", 32'h3E80_0000, 32'hBE00_0000, 0);
    start_pair(32'h3F80_0000, 32'h0000_0000);
    finish_pair("t4_zero_canon", 32'h0000_0000, 32'h0000_0000, 0);

    // Backpressure with in_valid activity in DONE
    start_pair(32'h3F00_0000, 32'h3F80_0000);
    wait_done(lat);
    check("t5_latency", lat, 4 * OW);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      y_in = 32'h4000_0000;
      t_in = 32'h4040_0000;
      tick();
      check("t5_hold_deriv", deriv_out, 32'h3E80_0000);
      check("t5_hold_delta", delta_out, 32'h3E00_0000);
      check("t5_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("t5_out_valid_high", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("t5_exit_in_ready", {31'd0, in_ready}, 32'd1);
    check("t5_exit_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_exit_deriv_kept", deriv_out, 32'h3E80_0000);
    tick();
    check("t5_no_same_cycle_accept", {31'd0, in_ready}, 32'd1);

    // Reset during MUL1
    start_pair(32'h3F40_0000, 32'h0000_0000);
    repeat (2 * OW) tick();
    check("t6_busy_before_rst", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_deriv", deriv_out, 32'h0);
    check("t6_rst_delta", delta_out, 32'h0);
    check("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    start_pair(32'h3F00_0000, 32'h3F80_0000);
    finish_pair("t6_after_rst", 32'h3E80_0000, 32'h3E00_0000, 0);

    // Random pairs against the real-arithmetic model
    for (int n = 0; n < 30; n++) begin
      ry = {1'b0, 8'($urandom_range(117, 126)), 23'($urandom)};
      case ($urandom_range(0, 3))
        0:       rt = 32'h0000_0000;
        1:       rt = 32'h3F80_0000;
        2:       rt = ry;
        default: rt = {1'b0, 8'($urandom_range(117, 126)), 23'($urandom)};
      endcase
      model(ry, rt, ed, edl);
      start_pair(ry, rt);
      finish_pair("rand", ed, edl, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
